// File: rtl/m_iter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : m_iter_pkg                                                   |
// | Description : Shared types and constants for the iterative M-extension     |
// |               co-processor: FSM state encoding, funct3 operation encoding, |
// |               and the opcode/funct7 pattern that selects an M instruction. |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package m_iter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } funct3_t;

  localparam logic [6:0] OPCODE = 7'b0110011;
  localparam logic [6:0] FUNCT7 = 7'b0000001;

  // funct3[2] separates the divide group from the multiply group.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

  // DIV and REM are the signed divide-group operations (funct3[0] clear).
  function automatic logic is_signed_div(input logic [2:0] f3);
    return f3[2] & ~f3[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/m_iter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : m_iter_if                                                    |
// | Description : PCPI-style co-processor bus between the core and the         |
// |               iterative multiply/divide unit.                              |
// | Signals     : pcpi_valid/pcpi_insn/pcpi_rs1/pcpi_rs2  core -> unit         |
// |               pcpi_wr/pcpi_rd/pcpi_wait/pcpi_ready     unit -> core        |
// | Modports    : master (core side), slave (unit side)                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface m_iter_if #(
  parameter int XLEN = 32
);

  logic            pcpi_valid;
  logic [31:0]     pcpi_insn;
  logic [XLEN-1:0] pcpi_rs1;
  logic [XLEN-1:0] pcpi_rs2;
  logic            pcpi_wr;
  logic [XLEN-1:0] pcpi_rd;
  logic            pcpi_wait;
  logic            pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

endinterface

`default_nettype wire

// File: rtl/m_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : m_div_step                                                   |
// | Description : Combinational block performing DIV_STEP restoring-division   |
// |               steps on unsigned magnitudes.                                |
// | Ports       : i_rem  partial remainder in  (XLEN+1)                        |
// |               i_quo  dividend/quotient shift register in (XLEN)            |
// |               i_dvs  divisor magnitude (XLEN)                              |
// |               o_rem  partial remainder out (XLEN+1)                        |
// |               o_quo  dividend/quotient shift register out (XLEN)           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module m_div_step #(
  parameter int XLEN     = 32,
  parameter int DIV_STEP = 1
) (
  input  logic [XLEN:0]   i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_dvs,
  output logic [XLEN:0]   o_rem,
  output logic [XLEN-1:0] o_quo
);

  // The dividend shifts out of the top of the quotient register while quotient
  // bits shift in at the bottom, so one register serves both roles.
  always_comb begin
    logic [XLEN:0]   w_rem;
    logic [XLEN-1:0] w_quo;
    logic [XLEN+1:0] w_shift;
    logic [XLEN+1:0] w_diff;
    w_rem   = i_rem;
    w_quo   = i_quo;
    w_shift = '0;
    w_diff  = '0;
    for (int k = 0; k < DIV_STEP; k++) begin
      w_shift = {w_rem, w_quo[XLEN-1]};
      // The remainder stays below the divisor, so the shifted value never
      // reaches bit XLEN+1; that bit of the difference is therefore a borrow.
      w_diff  = w_shift - {2'b00, i_dvs};
      w_quo   = {w_quo[XLEN-2:0], ~w_diff[XLEN+1]};
      w_rem   = w_diff[XLEN+1] ? w_shift[XLEN:0] : w_diff[XLEN:0];
    end
    o_rem = w_rem;
    o_quo = w_quo;
  end

endmodule

`default_nettype wire

// File: rtl/m_iter_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : m_iter_unit                                                  |
// | Description : Iterative RISC-V M-extension co-processor. Single-cycle      |
// |               multiply, DIV_STEP-bit-per-cycle restoring divide with a     |
// |               sign-fixup cycle, and a fast path for divide-by-zero and     |
// |               signed overflow.                                             |
// | Ports       : clk     clock, rising edge                                   |
// |               resetn  asynchronous reset, active high                      |
// |               pcpi    slave side of m_iter_if (valid/insn/rs1/rs2 in,      |
// |                       wr/rd/wait/ready out)                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module m_iter_unit #(
  parameter int XLEN     = 32,
  parameter int DIV_STEP = 1
) (
  input  logic   clk,
  input  logic   resetn,
  m_iter_if.slave pcpi
);

  import m_iter_pkg::*;

  localparam int            NSTEP     = XLEN / DIV_STEP;
  localparam int            CW        = $clog2(NSTEP);
  localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);

  generate
    if (!((XLEN == 32 || XLEN == 64) &&
          (DIV_STEP == 1 || DIV_STEP == 2 || DIV_STEP == 4))) begin : g_param_chk
      $error("m_iter_unit: unsupported XLEN/DIV_STEP combination");
    end
  endgenerate

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_quo;
  logic [XLEN:0]   r_rem;
  logic [XLEN-1:0] r_dvs;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_result;

  // ---------------- accept decode ----------------
  logic [2:0]      w_f3;
  logic            w_accept;
  logic            w_sdiv;
  logic            w_s1_neg;
  logic            w_s2_neg;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_unused_insn;

  assign w_f3     = pcpi.pcpi_insn[14:12];
  assign w_accept = (r_state == ST_IDLE) && pcpi.pcpi_valid &&
                    (pcpi.pcpi_insn[6:0] == OPCODE) &&
                    (pcpi.pcpi_insn[31:25] == FUNCT7);
  assign w_unused_insn = ^{pcpi.pcpi_insn[24:15], pcpi.pcpi_insn[11:7]};

  assign w_sdiv   = is_signed_div(w_f3);
  assign w_s1_neg = w_sdiv & pcpi.pcpi_rs1[XLEN-1];
  assign w_s2_neg = w_sdiv & pcpi.pcpi_rs2[XLEN-1];
  assign w_mag1   = w_s1_neg ? (~pcpi.pcpi_rs1 + 1'b1) : pcpi.pcpi_rs1;
  assign w_mag2   = w_s2_neg ? (~pcpi.pcpi_rs2 + 1'b1) : pcpi.pcpi_rs2;

  assign w_div0    = (pcpi.pcpi_rs2 == '0);
  assign w_ovf     = w_sdiv && (pcpi.pcpi_rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (pcpi.pcpi_rs2 == '1);
  assign w_special = is_div_op(w_f3) && (w_div0 || w_ovf);

  // funct3[1] picks the remainder flavour within the divide group.
  always_comb begin
    w_special_res = '0;
    if (w_div0)
      w_special_res = w_f3[1] ? pcpi.pcpi_rs1 : '1;
    else
      w_special_res = w_f3[1] ? '0 : pcpi.pcpi_rs1;
  end

  // ---------------- multiply ----------------
  // Each operand is the (XLEN+1)-bit sign/zero extension; extending further to
  // 2*XLEN keeps the low 2*XLEN product bits exact.
  logic            w_a_sign;
  logic            w_b_sign;
  logic [2*XLEN-1:0] w_a_ext;
  logic [2*XLEN-1:0] w_b_ext;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_mul_res;

  assign w_a_sign  = (r_f3 != F3_MULHU) & r_rs1[XLEN-1];
  assign w_b_sign  = ((r_f3 == F3_MUL) || (r_f3 == F3_MULH)) & r_rs2[XLEN-1];
  assign w_a_ext   = {{XLEN{w_a_sign}}, r_rs1};
  assign w_b_ext   = {{XLEN{w_b_sign}}, r_rs2};
  assign w_prod    = w_a_ext * w_b_ext;
  assign w_mul_res = (r_f3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // ---------------- divide ----------------
  logic [XLEN:0]   w_step_rem;
  logic [XLEN-1:0] w_step_quo;
  logic [XLEN-1:0] w_fix_res;

  m_div_step #(
    .XLEN     (XLEN),
    .DIV_STEP (DIV_STEP)
  ) u_div_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  // Neg flags are only ever set for signed ops, so unsigned ops pass through.
  always_comb begin
    w_fix_res = '0;
    if (r_f3[1])
      w_fix_res = r_neg_r ? (~r_rem[XLEN-1:0] + 1'b1) : r_rem[XLEN-1:0];
    else
      w_fix_res = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // ---------------- next state / outputs ----------------
  logic            w_wait;
  logic            w_ready;
  logic [XLEN-1:0] w_rd;

  always_comb begin
    w_next  = r_state;
    w_wait  = 1'b0;
    w_ready = 1'b0;
    w_rd    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_special)
            w_next = ST_DONE;
          else if (is_div_op(w_f3))
            w_next = ST_DIV;
          else
            w_next = ST_MUL;
        end
      end
      ST_MUL: begin
        w_wait = 1'b1;
        w_next = pcpi.pcpi_valid ? ST_DONE : ST_IDLE;
      end
      ST_DIV: begin
        w_wait = 1'b1;
        if (!pcpi.pcpi_valid)
          w_next = ST_IDLE;
        else if (r_cnt == LAST_STEP)
          w_next = ST_FIX;
      end
      ST_FIX: begin
        w_wait = 1'b1;
        w_next = pcpi.pcpi_valid ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        w_ready = 1'b1;
        w_rd    = r_result;
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign pcpi.pcpi_wait  = w_wait;
  assign pcpi.pcpi_ready = w_ready;
  assign pcpi.pcpi_wr    = w_ready;
  assign pcpi.pcpi_rd    = w_rd;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_cnt    <= '0;
      r_f3     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_f3     <= w_f3;
            r_rs1    <= pcpi.pcpi_rs1;
            r_rs2    <= pcpi.pcpi_rs2;
            r_quo    <= w_mag1;
            r_dvs    <= w_mag2;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= w_s1_neg ^ w_s2_neg;
            r_neg_r  <= w_s1_neg;
            r_result <= w_special_res;
          end
        end
        ST_MUL: r_result <= w_mul_res;
        ST_DIV: begin
          r_quo <= w_step_quo;
          r_rem <= w_step_rem;
          r_cnt <= (r_cnt == LAST_STEP) ? '0 : r_cnt + CW'(1);
        end
        ST_FIX: r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/m_iter_unit.md
M_ITER_UNIT -- requirements
Module: m_iter_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width; legal values 32 and 64.
REQ-002 SHALL have parameter DIV_STEP, default 1: quotient bits retired per divide cycle; legal values 1, 2 and 4; an illegal XLEN/DIV_STEP SHALL stop elaboration with an error.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-high.
REQ-005 pcpi_valid  input  1  the core offers an instruction.
REQ-006 pcpi_insn  input  32  the offered instruction.
REQ-007 pcpi_rs1, pcpi_rs2  input  XLEN  source operands, held stable by the core while pcpi_valid is high.
REQ-008 pcpi_wr  output  1  write the result to rd.
REQ-009 pcpi_rd  output  XLEN  result.
REQ-010 pcpi_wait  output  1  the unit is computing.
REQ-011 pcpi_ready  output  1  the result is valid.

Function
REQ-012 Accept SHALL occur when state is IDLE, pcpi_valid=1, opcode=0110011 and funct7=0000001; any other instruction SHALL be ignored.
REQ-013 At accept, SHALL latch funct3, operand magnitudes for signed ops, flags neg_q=sign(rs1) XOR sign(rs2) and neg_r=sign(rs1), and the raw operands.
REQ-014 States SHALL be IDLE, MUL, DIV, FIX, DONE.
- Accept of MUL/MULH/MULHSU/MULHU: IDLE->MUL.
- Accept of DIV/DIVU/REM/REMU, normal case: IDLE->DIV.
- Accept of a divide special case: IDLE->DONE.
- MUL->DONE.
- DIV->DIV until the step counter reaches XLEN/DIV_STEP-1, then DIV->FIX.
- FIX->DONE.
- DONE->IDLE.
REQ-015 MUL state SHALL form the 2*XLEN product of (XLEN+1)-bit operands, each sign- or zero-extended per funct3, in one cycle.
- MUL SHALL return the low XLEN bits.
- MULH, MULHSU and MULHU SHALL return the high XLEN bits.
REQ-016 DIV state SHALL perform DIV_STEP restoring-division steps per cycle on unsigned magnitudes, using an (XLEN+1)-bit partial remainder.
REQ-017 FIX SHALL negate the quotient when neg_q=1 for DIV and negate the remainder when neg_r=1 for REM; unsigned ops SHALL pass through unchanged.
REQ-018 Divide by zero SHALL take the special path.
- DIV/DIVU SHALL return all-ones.
- REM/REMU SHALL return rs1.
REQ-019 Signed overflow (rs1=-2^(XLEN-1), rs2=-1) SHALL take the special path.
- DIV SHALL return rs1.
- REM SHALL return 0.
REQ-020 Latency, with accept at cycle N, SHALL be:
- multiply: ready at N+2;
- normal divide: ready at N+XLEN/DIV_STEP+2;
- special divide: ready at N+1.
REQ-021 pcpi_wait SHALL be 1 exactly while in MUL, DIV or FIX, and 0 otherwise.
REQ-022 pcpi_ready and pcpi_wr SHALL both be 1 exactly in the DONE cycle, for one cycle only.
REQ-023 pcpi_rd SHALL be valid in the DONE cycle; it SHALL be 0 in all other cycles.
REQ-024 If pcpi_valid falls while in MUL, DIV or FIX, the unit SHALL go to IDLE next cycle with no ready pulse; an accept SHALL be possible in the following cycle.
REQ-025 No accept SHALL occur in DONE; back-to-back operations SHALL be spaced by at least one IDLE cycle.

Reset
REQ-026 resetn=1 SHALL immediately force the following, including mid-operation:
- state=IDLE;
- step counter=0;
- operand, quotient, remainder and product registers=0;
- pcpi_wr=0, pcpi_ready=0, pcpi_wait=0, pcpi_rd=0.
REQ-027 After reset release, the first accept SHALL be possible on the first rising edge.

Structure
REQ-028 Shared package m_iter_pkg SHALL hold the state enum, the funct3 enum (MUL..REMU), and the OPCODE and FUNCT7 constants.
REQ-029 The DIV_STEP-bit restoring step SHALL be a combinational sub-module m_div_step, parametrised by XLEN and DIV_STEP.
REQ-030 The step counter SHALL be $clog2(XLEN/DIV_STEP) bits wide.

Verification (XLEN=32 unless stated)
REQ-031 MULH, rs1=0xFFFFFFFF, rs2=0x00000002 -> rd=0xFFFFFFFF at N+2; MULHU with the same operands -> rd=0x00000001.
REQ-032 DIV, rs1=0xFFFFFFF9, rs2=2 -> rd=0xFFFFFFFD at N+34; REM with the same operands -> rd=0xFFFFFFFF.
REQ-033 DIVU, rs1=5, rs2=0 -> rd=0xFFFFFFFF at N+1; REMU with the same operands -> rd=5; DIV, rs1=0x80000000, rs2=0xFFFFFFFF -> rd=0x80000000; REM with the same operands -> rd=0.
REQ-034 DIVU 1000/7 with pcpi_valid dropped at N+10 -> IDLE, no ready; then MUL 3*4 -> rd=12 at N'+2.
REQ-035 resetn pulsed at N+5 during DIV -> all outputs 0 immediately, state IDLE; a following DIVU 100/7 -> rd=14.
REQ-036 With DIV_STEP=2, DIVU 100/7 -> rd=14 at N+18; with XLEN=64, DIV_STEP=4, REMU 2^63+5 / 10 -> rd=3 at N+18.
